// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit MIPS pipeline: latches decoded operands/control,
// detects load-use hazards, and forwards EX/MEM and MEM/WB results into the ALU operands.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idValid,
    input  logic [REG_W-1:0]  idRs,
    input  logic [REG_W-1:0]  idRt,
    input  logic [REG_W-1:0]  idRd,
    input  logic [DATA_W-1:0] idRsData,
    input  logic [DATA_W-1:0] idRtData,
    input  logic [DATA_W-1:0] idImm,
    input  logic              idAluSrc,
    input  logic [OP_W-1:0]   idAluOp,
    input  logic              idMemRead,
    input  logic              idMemWrite,
    input  logic              idRegWrite,
    input  logic              idMemToReg,
    input  logic              flush,
    input  logic              exMemRegWrite,
    input  logic [REG_W-1:0]  exMemRd,
    input  logic [DATA_W-1:0] exMemAluResult,
    input  logic              memWbRegWrite,
    input  logic [REG_W-1:0]  memWbRd,
    input  logic [DATA_W-1:0] memWbData,
    output logic              stall,
    output logic              exValid,
    output logic [DATA_W-1:0] exA,
    output logic [DATA_W-1:0] exB,
    output logic [DATA_W-1:0] exStoreData,
    output logic [OP_W-1:0]   exAluOp,
    output logic [REG_W-1:0]  exRd,
    output logic              exMemRead,
    output logic              exMemWrite,
    output logic              exRegWrite,
    output logic              exMemToReg,
    output logic [1:0]        fwdA,
    output logic [1:0]        fwdB
);

    logic              r_valid;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_rsData;
    logic [DATA_W-1:0] r_rtData;
    logic [DATA_W-1:0] r_imm;
    logic              r_aluSrc;
    logic [OP_W-1:0]   r_aluOp;
    logic              r_memRead;
    logic              r_memWrite;
    logic              r_regWrite;
    logic              r_memToReg;

    logic              w_rsHit;
    logic              w_rtHit;
    logic              w_stall;
    logic [1:0]        w_fwdA;
    logic [1:0]        w_fwdB;
    logic [DATA_W-1:0] w_rsFwd;
    logic [DATA_W-1:0] w_rtFwd;

    // rt only matters when it is actually read as a register: ALU B operand or store data.
    assign w_rsHit = (r_rd == idRs);
    assign w_rtHit = (r_rd == idRt) && (!idAluSrc || idMemWrite);
    assign w_stall = !rst && r_valid && r_memRead && idValid &&
                     (r_rd != '0) && (w_rsHit || w_rtHit);

    always_ff @(posedge clk) begin
        if (rst || flush || w_stall) begin
            // Reset and bubble share one clear path; every field zeroes for determinism.
            r_valid    <= 1'b0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_rsData   <= '0;
            r_rtData   <= '0;
            r_imm      <= '0;
            r_aluSrc   <= 1'b0;
            r_aluOp    <= '0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_regWrite <= 1'b0;
            r_memToReg <= 1'b0;
        end else begin
            r_valid    <= idValid;
            r_rs       <= idRs;
            r_rt       <= idRt;
            r_rd       <= idRd;
            r_rsData   <= idRsData;
            r_rtData   <= idRtData;
            r_imm      <= idImm;
            r_aluSrc   <= idAluSrc;
            r_aluOp    <= idAluOp;
            r_memRead  <= idMemRead;
            r_memWrite <= idMemWrite;
            r_regWrite <= idRegWrite;
            r_memToReg <= idMemToReg;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
    always_comb begin
        w_fwdA = 2'b00;
        if (exMemRegWrite && (exMemRd != '0) && (exMemRd == r_rs))
            w_fwdA = 2'b10;
        else if (memWbRegWrite && (memWbRd != '0) && (memWbRd == r_rs))
            w_fwdA = 2'b01;
    end

    always_comb begin
        w_fwdB = 2'b00;
        if (exMemRegWrite && (exMemRd != '0) && (exMemRd == r_rt))
            w_fwdB = 2'b10;
        else if (memWbRegWrite && (memWbRd != '0) && (memWbRd == r_rt))
            w_fwdB = 2'b01;
    end

    always_comb begin
        case (w_fwdA)
            2'b10:   w_rsFwd = exMemAluResult;
            2'b01:   w_rsFwd = memWbData;
            default: w_rsFwd = r_rsData;
        endcase
        case (w_fwdB)
            2'b10:   w_rtFwd = exMemAluResult;
            2'b01:   w_rtFwd = memWbData;
            default: w_rtFwd = r_rtData;
        endcase
    end

    assign stall       = w_stall;
    assign exValid     = r_valid;
    assign exA         = w_rsFwd;
    assign exB         = r_aluSrc ? r_imm : w_rtFwd;
    assign exStoreData = w_rtFwd;
    assign exAluOp     = r_aluOp;
    assign exRd        = r_rd;
    assign exMemRead   = r_memRead;
    assign exMemWrite  = r_memWrite;
    assign exRegWrite  = r_regWrite;
    assign exMemToReg  = r_memToReg;
    assign fwdA        = w_fwdA;
    assign fwdB        = w_fwdB;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding priority, r0 guard,
// load-use stall/bubble, flush-over-stall and reset-over-stall.
module tb_id_ex_stage;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int OP_W   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              idValid;
    logic [REG_W-1:0]  idRs, idRt, idRd;
    logic [DATA_W-1:0] idRsData, idRtData, idImm;
    logic              idAluSrc;
    logic [OP_W-1:0]   idAluOp;
    logic              idMemRead, idMemWrite, idRegWrite, idMemToReg;
    logic              flush;
    logic              exMemRegWrite;
    logic [REG_W-1:0]  exMemRd;
    logic [DATA_W-1:0] exMemAluResult;
    logic              memWbRegWrite;
    logic [REG_W-1:0]  memWbRd;
    logic [DATA_W-1:0] memWbData;
    logic              stall, exValid;
    logic [DATA_W-1:0] exA, exB, exStoreData;
    logic [OP_W-1:0]   exAluOp;
    logic [REG_W-1:0]  exRd;
    logic              exMemRead, exMemWrite, exRegWrite, exMemToReg;
    logic [1:0]        fwdA, fwdB;

    int tests = 0;
    int fails = 0;

    id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .idValid(idValid),
        .idRs(idRs), .idRt(idRt), .idRd(idRd),
        .idRsData(idRsData), .idRtData(idRtData), .idImm(idImm),
        .idAluSrc(idAluSrc), .idAluOp(idAluOp),
        .idMemRead(idMemRead), .idMemWrite(idMemWrite),
        .idRegWrite(idRegWrite), .idMemToReg(idMemToReg),
        .flush(flush),
        .exMemRegWrite(exMemRegWrite), .exMemRd(exMemRd), .exMemAluResult(exMemAluResult),
        .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd), .memWbData(memWbData),
        .stall(stall), .exValid(exValid), .exA(exA), .exB(exB), .exStoreData(exStoreData),
        .exAluOp(exAluOp), .exRd(exRd),
        .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exRegWrite(exRegWrite), .exMemToReg(exMemToReg),
        .fwdA(fwdA), .fwdB(fwdB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        idValid = 0; idRs = 0; idRt = 0; idRd = 0;
        idRsData = 0; idRtData = 0; idImm = 0; idAluSrc = 0; idAluOp = 0;
        idMemRead = 0; idMemWrite = 0; idRegWrite = 0; idMemToReg = 0;
    endtask

    task automatic fwd_clear();
        exMemRegWrite = 0; exMemRd = 0; exMemAluResult = 0;
        memWbRegWrite = 0; memWbRd = 0; memWbData = 0;
    endtask

    // LW r5, 4(r1)
    task automatic id_lw5();
        id_clear();
        idValid = 1; idRs = 1; idRt = 5; idRd = 5; idImm = 16'h0004; idAluSrc = 1;
        idMemRead = 1; idRegWrite = 1; idMemToReg = 1;
    endtask

    // ADD r7, r5, r6
    task automatic id_add_dep();
        id_clear();
        idValid = 1; idRs = 5; idRt = 6; idRd = 7;
        idRsData = 16'h0099; idRtData = 16'h0003; idAluOp = 3'd2; idRegWrite = 1;
    endtask

    initial begin
        // Reset with junk inputs
        rst = 1; flush = 0;
        idValid = 1; idRs = 3; idRt = 4; idRd = 6; idRsData = 16'hDEAD; idRtData = 16'hBEEF;
        idImm = 16'h1234; idAluSrc = 1; idAluOp = 3'd7;
        idMemRead = 1; idMemWrite = 1; idRegWrite = 1; idMemToReg = 1;
        exMemRegWrite = 1; exMemRd = 3; exMemAluResult = 16'h7777;
        memWbRegWrite = 1; memWbRd = 4; memWbData = 16'h8888;
        tick(); tick();
        chk("rst_exValid", exValid, 0);
        chk("rst_exA", exA, 0);
        chk("rst_exB", exB, 0);
        chk("rst_store", exStoreData, 0);
        chk("rst_fwdA", fwdA, 0);
        chk("rst_fwdB", fwdB, 0);
        chk("rst_exRd", exRd, 0);
        chk("rst_aluOp", exAluOp, 0);
        chk("rst_ctrl", {exMemRead, exMemWrite, exRegWrite, exMemToReg}, 0);
        chk("rst_stall", stall, 0);

        // Release, idle
        rst = 0; id_clear(); fwd_clear();
        tick();
        chk("idle_exValid", exValid, 0);

        // Plain capture: ADD r3, r1, r2
        idValid = 1; idRs = 1; idRt = 2; idRd = 3; idRsData = 16'h0005; idRtData = 16'h0007;
        idAluOp = 3'd2; idRegWrite = 1;
        tick();
        id_clear();
        #1;
        chk("cap_exValid", exValid, 1);
        chk("cap_exA", exA, 16'h0005);
        chk("cap_exB", exB, 16'h0007);
        chk("cap_store", exStoreData, 16'h0007);
        chk("cap_exRd", exRd, 3);
        chk("cap_regWrite", exRegWrite, 1);
        chk("cap_aluOp", exAluOp, 2);
        chk("cap_fwdA", fwdA, 0);
        chk("cap_fwdB", fwdB, 0);

        // Forward priority: rs = rt = r4
        idValid = 1; idRs = 4; idRt = 4; idRd = 2; idRsData = 16'h1111; idRtData = 16'h1111;
        idRegWrite = 1;
        tick();
        id_clear();
        exMemRegWrite = 1; exMemRd = 4; exMemAluResult = 16'hAAAA;
        memWbRegWrite = 1; memWbRd = 4; memWbData = 16'h5555;
        #1;
        chk("pri_exA", exA, 16'hAAAA);
        chk("pri_exB", exB, 16'hAAAA);
        chk("pri_fwdA", fwdA, 2'b10);
        chk("pri_fwdB", fwdB, 2'b10);
        exMemRegWrite = 0;
        #1;
        chk("wb_exA", exA, 16'h5555);
        chk("wb_store", exStoreData, 16'h5555);
        chk("wb_fwdA", fwdA, 2'b01);
        chk("wb_fwdB", fwdB, 2'b01);
        memWbRegWrite = 0;
        #1;
        chk("nofwd_exA", exA, 16'h1111);

        // r0 guard and immediate
        fwd_clear();
        idValid = 1; idRs = 0; idRt = 2; idRd = 1; idRsData = 16'h0000; idRtData = 16'h0042;
        idImm = 16'hFFF0; idAluSrc = 1; idRegWrite = 1;
        tick();
        id_clear();
        exMemRegWrite = 1; exMemRd = 0; exMemAluResult = 16'h1234;
        #1;
        chk("r0_exA", exA, 16'h0000);
        chk("r0_fwdA", fwdA, 2'b00);
        chk("imm_exB", exB, 16'hFFF0);
        chk("imm_fwdB", fwdB, 2'b00);
        chk("imm_store", exStoreData, 16'h0042);
        // fwdB still reports the rt select when B takes the immediate
        exMemRd = 2;
        #1;
        chk("imm_fwdB_rep", fwdB, 2'b10);
        chk("imm_exB_keep", exB, 16'hFFF0);
        chk("imm_store_fwd", exStoreData, 16'h1234);
        fwd_clear();

        // Load-use: LW r5 in EX, ADD r7, r5, r6 in ID
        id_lw5();
        tick();
        chk("lw_memRead", exMemRead, 1);
        chk("lw_exRd", exRd, 5);
        id_add_dep();
        #1;
        chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble_valid", exValid, 0);
        chk("lu_bubble_regw", exRegWrite, 0);
        chk("lu_stall_once", stall, 0);
        // LW now in EX/MEM; next edge it moves to MEM/WB as ADD enters EX
        exMemRegWrite = 1; exMemRd = 5; exMemAluResult = 16'h0004;
        tick();
        id_clear();
        exMemRegWrite = 0; exMemRd = 0;
        memWbRegWrite = 1; memWbRd = 5; memWbData = 16'hBEEF;
        #1;
        chk("lu_add_valid", exValid, 1);
        chk("lu_add_rd", exRd, 7);
        chk("lu_fwdA", fwdA, 2'b01);
        chk("lu_exA", exA, 16'hBEEF);
        chk("lu_exB", exB, 16'h0003);
        fwd_clear();

        // Stall condition on rt depends on whether rt is really read
        id_lw5();
        tick();
        id_clear();
        idValid = 1; idRs = 1; idRt = 5; idAluSrc = 1; idMemWrite = 1;
        #1;
        chk("sw_rt_stall", stall, 1);
        idMemWrite = 0;
        #1;
        chk("imm_rt_nostall", stall, 0);
        idAluSrc = 0;
        #1;
        chk("reg_rt_stall", stall, 1);
        idValid = 0;
        #1;
        chk("noval_nostall", stall, 0);

        // Flush over stall: LW r5 still in EX, present dependent ADD with flush
        id_add_dep();
        flush = 1;
        #1;
        chk("fl_stall_comb", stall, 1);
        tick();
        flush = 0;
        id_clear();
        #1;
        chk("fl_exValid", exValid, 0);
        chk("fl_exMemWrite", exMemWrite, 0);
        chk("fl_exRegWrite", exRegWrite, 0);
        chk("fl_not_captured", exRd, 0);

        // Reset mid-stall
        id_lw5();
        tick();
        id_add_dep();
        #1;
        chk("rs_pre_stall", stall, 1);
        rst = 1;
        #1;
        chk("rs_stall_forced", stall, 0);
        tick();
        rst = 0;
        id_clear();
        #1;
        chk("rs_exValid", exValid, 0);
        chk("rs_memRead", exMemRead, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
